// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
//
// Shared types and constants for the start-triggered countdown timer.
//
//   timer_state_t  : controller state (T_IDLE, T_RUN)
//   MODE_ONESHOT   : Mode value that stops the timer after one period
//   MODE_RELOAD    : Mode value that reloads Count and keeps running
// -----------------------------------------------------------------------------
package timer_pkg;

    typedef enum logic {
        T_IDLE = 1'b0,
        T_RUN  = 1'b1
    } timer_state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

endpackage : timer_pkg

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//
// Prescaler for the countdown timer. While enabled, an internal counter runs
// from 0 up to div and wraps back to 0; tick is high in the cycle the counter
// equals div, so one tick is produced every div+1 clocks. An all-ones div
// therefore yields 2^PS_WIDTH clocks per tick.
//
// Ports:
//   Clock   in  1         rising-edge clock
//   Reset   in  1         asynchronous active-low reset
//   clear   in  1         synchronous clear of the prescaler (wins over enable)
//   enable  in  1         advance the prescaler this cycle
//   div     in  PS_WIDTH  terminal count (clocks per tick minus one)
//   tick    out 1         high in the cycle the prescaler reaches div
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int PS_WIDTH = 4
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                clear,
    input  logic                enable,
    input  logic [PS_WIDTH-1:0] div,
    output logic                tick
);

    logic [PS_WIDTH-1:0] ps_cnt;
    logic                at_div;

    assign at_div = (ps_cnt == div);

    // The tick is consumed by the top in the same cycle, at the edge where the
    // prescaler wraps; this keeps reload periods gap-free.
    assign tick = enable && at_div;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples values from before the edge.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ps_cnt <= '0;
        end else if (clear) begin
            ps_cnt <= '0;
        end else if (enable) begin
            if (at_div) begin
                ps_cnt <= '0;
            end else begin
                ps_cnt <= ps_cnt + 1'b1;
            end
        end
    end

endmodule : tick_gen

// File: rtl/start_timer.sv
// -----------------------------------------------------------------------------
// start_timer
//
// Start-triggered countdown timer. A Start with non-zero Load latches Mode,
// Load and Prescale and begins a run; each prescaler tick decrements Count,
// and the tick that takes Count past 1 ends the period with a one-cycle Done
// pulse. One-shot runs then return to IDLE; auto-reload runs reload Count and
// continue. Abort stops everything without Done. A Start with Load=0 produces
// an immediate Done pulse and leaves the timer idle.
//
// Edge priority: Abort, then Start, then tick.
//
// Ports:
//   Clock     in  1         rising-edge clock
//   Reset     in  1         asynchronous active-low reset
//   Start     in  1         start / restart request (level sampled)
//   Abort     in  1         stop the run, no Done
//   Mode      in  1         0 = one-shot, 1 = auto-reload (latched on Start)
//   Load      in  WIDTH     ticks per period (latched on Start)
//   Prescale  in  PS_WIDTH  clocks per tick minus one (latched on Start)
//   Count     out WIDTH     ticks remaining in the current period
//   Busy      out 1         high while running
//   Done      out 1         one-cycle pulse at the end of each period
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module start_timer
    import timer_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PS_WIDTH = 4
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    input  logic                Abort,
    input  logic                Mode,
    input  logic [WIDTH-1:0]    Load,
    input  logic [PS_WIDTH-1:0] Prescale,
    output logic [WIDTH-1:0]    Count,
    output logic                Busy,
    output logic                Done
);

    timer_state_t        state;
    logic                mode_q;
    logic [WIDTH-1:0]    load_q;
    logic [PS_WIDTH-1:0] ps_q;

    logic                tick;
    logic                load_zero;
    logic                last_tick;

    assign load_zero = (Load == '0);
    assign last_tick = (Count == WIDTH'(1));

    // Any Start (even Load=0) and any Abort restart the prescaler, so an
    // in-flight partial tick never carries into the next run.
    tick_gen #(
        .PS_WIDTH (PS_WIDTH)
    ) u_tick_gen (
        .Clock  (Clock),
        .Reset  (Reset),
        .clear  (Abort || Start),
        .enable (state == T_RUN),
        .div    (ps_q),
        .tick   (tick)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state  <= T_IDLE;
            Count  <= '0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            mode_q <= MODE_ONESHOT;
            load_q <= '0;
            ps_q   <= '0;
        end else begin
            // Done is a pulse: it is only raised by the branches below.
            Done <= 1'b0;

            if (Abort) begin
                state <= T_IDLE;
                Count <= '0;
                Busy  <= 1'b0;
            end else if (Start) begin
                if (load_zero) begin
                    state <= T_IDLE;
                    Count <= '0;
                    Busy  <= 1'b0;
                    Done  <= 1'b1;
                end else begin
                    mode_q <= Mode;
                    load_q <= Load;
                    ps_q   <= Prescale;
                    state  <= T_RUN;
                    Count  <= Load;
                    Busy   <= 1'b1;
                end
            end else if (state == T_RUN && tick) begin
                if (!last_tick) begin
                    Count <= Count - 1'b1;
                end else begin
                    Done <= 1'b1;
                    if (mode_q == MODE_RELOAD) begin
                        Count <= load_q;
                    end else begin
                        state <= T_IDLE;
                        Count <= '0;
                        Busy  <= 1'b0;
                    end
                end
            end
        end
    end

endmodule : start_timer

// File: tb/tb_start_timer.sv
// -----------------------------------------------------------------------------
// tb_start_timer
//
// Self-checking bench for start_timer. The reference model tracks the start
// edge of the current run and derives Count/Busy/Done from elapsed clocks
// with plain arithmetic: ticks elapsed = elapsed / (Prescale+1), period =
// (Prescale+1) * Load.
// -----------------------------------------------------------------------------
module tb_start_timer;
    import timer_pkg::*;

    localparam int WIDTH    = 8;
    localparam int PS_WIDTH = 4;

    logic                Clock    = 1'b0;
    logic                Reset    = 1'b0;
    logic                Start    = 1'b0;
    logic                Abort    = 1'b0;
    logic                Mode     = 1'b0;
    logic [WIDTH-1:0]    Load     = '0;
    logic [PS_WIDTH-1:0] Prescale = '0;
    logic [WIDTH-1:0]    Count;
    logic                Busy;
    logic                Done;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit m_busy  = 0;
    bit m_done  = 0;
    bit m_mode  = 0;
    int m_count = 0;
    int m_t0    = 0;
    int m_cyc   = 0;
    int m_L     = 0;
    int m_P     = 0;

    start_timer #(
        .WIDTH    (WIDTH),
        .PS_WIDTH (PS_WIDTH)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .Abort    (Abort),
        .Mode     (Mode),
        .Load     (Load),
        .Prescale (Prescale),
        .Count    (Count),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 Clock = ~Clock;

    task automatic model_clear();
        m_busy  = 0;
        m_done  = 0;
        m_count = 0;
    endtask

    // Expected outputs after the edge that just happened, from the inputs
    // that were applied to it.
    task automatic model_edge();
        int k;
        int per;
        int r;
        m_cyc++;
        m_done = 0;
        if (!Reset || Abort) begin
            m_busy  = 0;
            m_count = 0;
        end else if (Start) begin
            if (Load != 0) begin
                m_L     = int'(Load);
                m_P     = int'(Prescale);
                m_mode  = Mode;
                m_t0    = m_cyc;
                m_busy  = 1;
                m_count = m_L;
            end else begin
                m_busy  = 0;
                m_count = 0;
                m_done  = 1;
            end
        end else if (m_busy) begin
            k   = m_cyc - m_t0;
            per = (m_P + 1) * m_L;
            if (m_mode == MODE_ONESHOT) begin
                if (k == per) begin
                    m_busy  = 0;
                    m_count = 0;
                    m_done  = 1;
                end else begin
                    m_count = m_L - k / (m_P + 1);
                end
            end else begin
                r = k % per;
                if (r == 0) begin
                    m_count = m_L;
                    m_done  = 1;
                end else begin
                    m_count = m_L - r / (m_P + 1);
                end
            end
        end else begin
            m_count = 0;
        end
    endtask

    // Drive one cycle of inputs, take the edge, update model, settle.
    task automatic step(input bit s, input bit a, input bit md, input int ld, input int ps);
        Start    = s;
        Abort    = a;
        Mode     = md;
        Load     = WIDTH'(ld);
        Prescale = PS_WIDTH'(ps);
        @(posedge Clock);
        model_edge();
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        Reset = 1'b0;
        #12;
        n_checks++;
        if ({Count, Busy, Done} !== {WIDTH'(0), 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: Count=%0d Busy=%b Done=%b, required 0 0 0", Count, Busy, Done);
        end
        model_clear();
        @(posedge Clock);
        m_cyc++;
        #1;
        Reset = 1'b1;
        idle();
        n_checks++;
        if ({Count, Busy, Done} !== {WIDTH'(0), 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_release: Count=%0d Busy=%b Done=%b, required 0 0 0", Count, Busy, Done);
        end
    endtask

    task automatic test_oneshot();
        int exp_c;
        bit exp_b;
        bit exp_d;
        step(1, 0, 0, 5, 0);
        for (int i = 0; i < 8; i++) begin
            exp_c = (i < 5) ? 5 - i : 0;
            exp_b = (i < 5);
            exp_d = (i == 5);
            n_checks++;
            if ({Count, Busy, Done} !== {WIDTH'(exp_c), exp_b, exp_d}) begin
                n_fail++;
                $display("FAIL oneshot cycle %0d: Count=%0d Busy=%b Done=%b, required %0d %b %b",
                         i, Count, Busy, Done, exp_c, exp_b, exp_d);
            end
            n_checks++;
            if ({Count, Busy, Done} !== {m_count[WIDTH-1:0], m_busy, m_done}) begin
                n_fail++;
                $display("FAIL oneshot_model cycle %0d: Count=%0d Busy=%b Done=%b, model %0d %b %b",
                         i, Count, Busy, Done, m_count, m_busy, m_done);
            end
            idle();
        end
    endtask

    task automatic test_reload();
        int last_done;
        int n_done;
        int bad_gap;
        int busy_drop;
        last_done = 0;
        n_done    = 0;
        bad_gap   = 0;
        busy_drop = 0;
        step(1, 0, 1, 3, 2);
        for (int i = 1; i <= 40; i++) begin
            idle();
            n_checks++;
            if ({Count, Busy, Done} !== {m_count[WIDTH-1:0], m_busy, m_done}) begin
                n_fail++;
                $display("FAIL reload cycle %0d: Count=%0d Busy=%b Done=%b, model %0d %b %b",
                         i, Count, Busy, Done, m_count, m_busy, m_done);
            end
            if (!Busy) busy_drop++;
            if (Done) begin
                if (i - last_done != 9) bad_gap++;
                if (Count !== WIDTH'(3)) bad_gap++;
                last_done = i;
                n_done++;
            end
        end
        n_checks++;
        if (n_done < 4 || bad_gap != 0 || busy_drop != 0) begin
            n_fail++;
            $display("FAIL reload_period: done=%0d bad_gaps=%0d busy_low=%0d, required >=4 0 0",
                     n_done, bad_gap, busy_drop);
        end
        step(0, 1, 0, 0, 0);
    endtask

    task automatic test_restart();
        int n_done;
        int wait_cyc;
        bit found;
        n_done = 0;
        found  = 0;
        step(1, 0, 0, 6, 0);
        for (int i = 0; i < 20 && !found; i++) begin
            if (Done) n_done++;
            if (Count == WIDTH'(2)) found = 1;
            else idle();
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL restart_wait: Count=%0d never reached required 2", Count);
        end
        step(1, 0, 0, 6, 0);
        n_checks++;
        if ({Count, Busy, Done} !== {WIDTH'(6), 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL restart_reload: Count=%0d Busy=%b Done=%b, required 6 1 0", Count, Busy, Done);
        end
        wait_cyc = 0;
        while (!Done && wait_cyc < 20) begin
            idle();
            wait_cyc++;
            n_checks++;
            if ({Count, Busy, Done} !== {m_count[WIDTH-1:0], m_busy, m_done}) begin
                n_fail++;
                $display("FAIL restart_model: Count=%0d Busy=%b Done=%b, model %0d %b %b",
                         Count, Busy, Done, m_count, m_busy, m_done);
            end
        end
        n_checks++;
        if (wait_cyc != 6 || n_done != 0) begin
            n_fail++;
            $display("FAIL restart_timing: done after %0d cycles, early dones %0d, required 6 and 0",
                     wait_cyc, n_done);
        end
        idle();
    endtask

    task automatic test_abort();
        int n_done;
        n_done = 0;
        step(1, 0, 0, 10, 1);
        repeat (5) idle();
        step(0, 1, 0, 0, 0);
        n_checks++;
        if ({Count, Busy, Done} !== {WIDTH'(0), 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort: Count=%0d Busy=%b Done=%b, required 0 0 0", Count, Busy, Done);
        end
        repeat (25) begin
            idle();
            if (Done || Busy) n_done++;
        end
        step(1, 0, 0, 10, 0);
        repeat (3) idle();
        step(1, 1, 1, 10, 0);
        n_checks++;
        if ({Count, Busy, Done} !== {WIDTH'(0), 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_start: Count=%0d Busy=%b Done=%b, required 0 0 0", Count, Busy, Done);
        end
        repeat (25) begin
            idle();
            if (Done || Busy) n_done++;
        end
        n_checks++;
        if (n_done != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: %0d cycles with Done/Busy after abort, required 0", n_done);
        end
    endtask

    task automatic test_load_zero();
        step(1, 0, 1, 0, 3);
        n_checks++;
        if ({Count, Busy, Done} !== {WIDTH'(0), 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL load_zero: Count=%0d Busy=%b Done=%b, required 0 0 1", Count, Busy, Done);
        end
        idle();
        n_checks++;
        if ({Count, Busy, Done} !== {WIDTH'(0), 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL load_zero_after: Count=%0d Busy=%b Done=%b, required 0 0 0", Count, Busy, Done);
        end
        step(1, 0, 0, 4, 0);
        idle();
        step(1, 0, 0, 0, 0);
        n_checks++;
        if ({Count, Busy, Done} !== {WIDTH'(0), 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL load_zero_run: Count=%0d Busy=%b Done=%b, required 0 0 1", Count, Busy, Done);
        end
        idle();
    endtask

    task automatic test_max();
        int wait_cyc;
        int n_bad;
        int expected;
        expected = (15 + 1) * 255;
        n_bad    = 0;
        wait_cyc = 0;
        step(1, 0, 0, 255, 15);
        while (!Done && wait_cyc < 5000) begin
            idle();
            wait_cyc++;
            if ({Count, Busy, Done} !== {m_count[WIDTH-1:0], m_busy, m_done}) begin
                if (n_bad < 4)
                    $display("FAIL max_model cycle %0d: Count=%0d Busy=%b Done=%b, model %0d %b %b",
                             wait_cyc, Count, Busy, Done, m_count, m_busy, m_done);
                n_bad++;
            end
        end
        n_checks++;
        if (n_bad != 0) n_fail++;
        n_checks++;
        if (wait_cyc != expected || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL max_period: Done after %0d clocks Busy=%b, required %0d and 0",
                     wait_cyc, Busy, expected);
        end
        idle();
    endtask

    task automatic test_async_reset();
        int n_bad;
        n_bad = 0;
        step(1, 0, 0, 8, 1);
        repeat (4) idle();
        #2;
        Reset = 1'b0;
        #1;
        model_clear();
        n_checks++;
        if ({Count, Busy, Done} !== {WIDTH'(0), 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: Count=%0d Busy=%b Done=%b, required 0 0 0", Count, Busy, Done);
        end
        idle();
        Reset = 1'b1;
        repeat (30) begin
            idle();
            if (Done || Busy || Count != 0) n_bad++;
        end
        n_checks++;
        if (n_bad != 0) begin
            n_fail++;
            $display("FAIL async_reset_after: %0d active cycles after release, required 0", n_bad);
        end
    endtask

    task automatic test_random();
        int n_bad;
        bit s;
        bit a;
        int ld;
        n_bad = 0;
        for (int i = 0; i < 3000; i++) begin
            s  = ($urandom_range(0, 99) < 5);
            a  = ($urandom_range(0, 99) < 2);
            ld = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
            step(s, a, 1'($urandom_range(0, 1)), ld, int'($urandom_range(0, 3)));
            n_checks++;
            if ({Count, Busy, Done} !== {m_count[WIDTH-1:0], m_busy, m_done}) begin
                n_fail++;
                if (n_bad < 8)
                    $display("FAIL random cycle %0d: Count=%0d Busy=%b Done=%b, model %0d %b %b",
                             i, Count, Busy, Done, m_count, m_busy, m_done);
                n_bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_reload();
        test_restart();
        test_abort();
        test_load_zero();
        test_max();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_start_timer
